// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush vectors for PC + N-1 pipeline latches, drain/halt FSM, perf counters.
// Latency: stall/flush are combinational from inputs and current state; FSM and counters update on the next edge.
// Backpressure: mem_busy freezes every latch; halt freezes everything until reset; drain blocks new fetches.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int RAW_STAGE  = 1,
    parameter int JMP_STAGE  = 1,
    parameter int BR_STAGE   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  raw_hazard,
    input  logic                  jump_failed,
    input  logic                  branch_failed,
    input  logic                  mem_busy,
    input  logic                  wb_halt,
    input  logic                  drain_req,
    input  logic [NUM_STAGES-2:0] stage_valid,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  halted,
    output logic                  drained,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DRAINED,
        S_HALT
    } state_t;

    // Contiguous run of ones covering latch indices lo..hi inclusive.
    function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] BR_FLUSH  = range_mask(1, BR_STAGE);
    localparam logic [NUM_STAGES-1:0] JMP_FLUSH = range_mask(1, JMP_STAGE);
    localparam logic [NUM_STAGES-1:0] RAW_STALL = range_mask(0, RAW_STAGE);
    localparam logic [NUM_STAGES-1:0] RAW_FLUSH = range_mask(RAW_STAGE + 1, RAW_STAGE + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

    state_t state;
    state_t state_nxt;
    logic   draining;

    assign draining = (state == S_DRAIN) || (state == S_DRAINED);
    assign halted   = (state == S_HALT);
    assign drained  = (state == S_DRAINED);

    // State register; reset returns to RUN from any state, including HALT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a retiring HLT (with memory idle) overrides everything, HALT is terminal.
    always_comb begin
        state_nxt = state;
        if (wb_halt && !mem_busy) begin
            state_nxt = S_HALT;
        end else begin
            case (state)
                S_RUN:     if (drain_req) state_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (!drain_req)                state_nxt = S_RUN;
                    else if (stage_valid == '0)    state_nxt = S_DRAINED;
                end
                S_DRAINED: if (!drain_req) state_nxt = S_RUN;
                default:   state_nxt = S_HALT;
            endcase
        end
    end

    // Stall/flush priority: halt > mem freeze > branch > RAW > jump; drain blocks fetch
    // except on a branch redirect, where the PC must still capture the target.
    always_comb begin
        stall = '0;
        flush = '0;
        if (!reset_n) begin
            stall = '0;
        end else if ((state == S_HALT) || wb_halt || mem_busy) begin
            stall = '1;
        end else if (branch_failed) begin
            flush = BR_FLUSH;
        end else begin
            if (raw_hazard) begin
                stall = RAW_STALL;
                flush = RAW_FLUSH;
            end else if (jump_failed) begin
                flush = JMP_FLUSH;
            end
            if (draining) begin
                stall[0] = 1'b1;
                flush[1] = 1'b1;
            end
        end
    end

    // Saturating performance counters, frozen once halted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != S_HALT) begin
            if (stall[0] && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((|flush) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
